// File: rtl/sim_axi_pkg.sv
// rtl/sim_axi_pkg.sv - shared AXI4 write-channel constants, FSM encodings and helpers
package sim_axi_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } wr_state_e;

    // Ceiling log2, used to derive AWSIZE from the data-bus byte width
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sim_axi_burst_writer.sv
// rtl/sim_axi_burst_writer.sv - AXI4 write-master stimulus source with scoreboard counters
module sim_axi_burst_writer
    import sim_axi_pkg::*;
#(
    parameter int DW      = 512,
    parameter int AW      = 64,
    parameter int MAX_OUT = 8
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [7:0]      cmd_len,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    output logic [AW-1:0]   M_AXI_AWADDR,
    output logic [7:0]      M_AXI_AWLEN,
    output logic            M_AXI_AWVALID,
    input  logic            M_AXI_AWREADY,
    output logic [2:0]      M_AXI_AWSIZE,
    output logic [1:0]      M_AXI_AWBURST,
    output logic [3:0]      M_AXI_AWID,
    output logic            M_AXI_AWLOCK,
    output logic [3:0]      M_AXI_AWCACHE,
    output logic [3:0]      M_AXI_AWQOS,
    output logic [2:0]      M_AXI_AWPROT,
    output logic [DW-1:0]   M_AXI_WDATA,
    output logic [DW/8-1:0] M_AXI_WSTRB,
    output logic            M_AXI_WLAST,
    output logic            M_AXI_WVALID,
    input  logic            M_AXI_WREADY,
    input  logic [1:0]      M_AXI_BRESP,
    input  logic            M_AXI_BVALID,
    output logic            M_AXI_BREADY,
    output logic [31:0]     bursts_sent,
    output logic [31:0]     bursts_ackd,
    output logic            resp_err,
    output logic            idle
);

    localparam logic [2:0] AWSIZE_C  = 3'(clog2(DW / 8));
    localparam logic [7:0] MAX_OUT_C = 8'(MAX_OUT);

    wr_state_e      state_q;
    logic [AW-1:0]  addr_q;
    logic [7:0]     len_q;
    logic [7:0]     beats_left_q;
    logic           awvalid_q;
    logic           wvalid_q;
    logic           wlast_q;
    logic           bready_q;
    logic [31:0]    beat_ctr_q;
    logic [7:0]     outstanding_q;
    logic [7:0]     outstanding_d;
    logic [31:0]    bursts_sent_q;
    logic [31:0]    bursts_ackd_q;
    logic           resp_err_q;

    logic cmd_hs;
    logic aw_hs;
    logic w_hs;
    logic b_hs;

    assign cmd_ready = (state_q == S_IDLE) && (outstanding_q < MAX_OUT_C) && resetn;
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign aw_hs     = awvalid_q && M_AXI_AWREADY;
    assign w_hs      = wvalid_q && M_AXI_WREADY;
    assign b_hs      = bready_q && M_AXI_BVALID;

    // Burst FSM: one burst at a time, address phase strictly before data phase
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            beats_left_q <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            wlast_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_hs) begin
                        addr_q       <= cmd_addr;
                        len_q        <= cmd_len;
                        beats_left_q <= cmd_len;
                        awvalid_q    <= 1'b1;
                        state_q      <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wlast_q   <= (len_q == 8'd0);
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_hs) begin
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            state_q  <= S_IDLE;
                        end else begin
                            beats_left_q <= beats_left_q - 8'd1;
                            wlast_q      <= (beats_left_q == 8'd1);
                        end
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                    wlast_q   <= 1'b0;
                end
            endcase
        end
    end

    // Outstanding bursts: AW adds one, B retires one; spurious B (nothing outstanding) is ignored
    always_comb begin
        outstanding_d = outstanding_q;
        if (aw_hs && !(b_hs && outstanding_q != 8'd0)) begin
            outstanding_d = outstanding_q + 8'd1;
        end else if (!aw_hs && b_hs && outstanding_q != 8'd0) begin
            outstanding_d = outstanding_q - 8'd1;
        end
    end

    // Beat pattern counter, statistics, sticky error and always-ready B channel
    always_ff @(posedge clk) begin
        if (!resetn) begin
            beat_ctr_q    <= '0;
            outstanding_q <= '0;
            bursts_sent_q <= '0;
            bursts_ackd_q <= '0;
            resp_err_q    <= 1'b0;
            bready_q      <= 1'b0;
        end else begin
            bready_q      <= 1'b1;
            outstanding_q <= outstanding_d;
            if (w_hs) begin
                beat_ctr_q <= beat_ctr_q + 32'd1;
            end
            if (w_hs && wlast_q) begin
                bursts_sent_q <= bursts_sent_q + 32'd1;
            end
            if (b_hs) begin
                bursts_ackd_q <= bursts_ackd_q + 32'd1;
                if (M_AXI_BRESP != RESP_OKAY) begin
                    resp_err_q <= 1'b1;
                end
            end
        end
    end

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWLEN   = len_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_AWSIZE  = AWSIZE_C;
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_AWID    = 4'd0;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'd0;
    assign M_AXI_AWQOS   = 4'd0;
    assign M_AXI_AWPROT  = 3'd0;
    assign M_AXI_WDATA   = {(DW / 32){beat_ctr_q}};
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = wlast_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign bursts_sent   = bursts_sent_q;
    assign bursts_ackd   = bursts_ackd_q;
    assign resp_err      = resp_err_q;
    assign idle          = (state_q == S_IDLE) && (outstanding_q == 8'd0);

endmodule
